op_resta_serial: RTL
====================

Name: op_resta_serial

Overview:
- Multi-cycle, bit-serial unsigned subtractor: Diff = A - B - Bin (mod 2^N), with borrow-out.
- It is the inverse operation of the ripple-carry adder in the ALU datapath.
- It processes one bit per clock, LSB first, through a single full-subtractor cell and a borrow flip-flop.
- It has a start/busy/done handshake so the ALU sequencer can issue subtractions and collect results.

Parameters:
- N, 4, operand and result width in bits (N >= 2).

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- A  input  N  minuend (unsigned), captured when start is accepted
- B  input  N  subtrahend (unsigned), captured when start is accepted
- Bin  input  1  borrow-in, captured when start is accepted
- Diff  output  N  registered difference
- Bout  output  1  registered borrow-out
- zero  output  1  registered flag, high when Diff == 0
- busy  output  1  high while an operation is in progress (RUN state)
- done  output  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is asynchronous and active-high.
- While rst is high:
  - state = IDLE.
  - Diff = 0, Bout = 0, zero = 0, busy = 0, done = 0.
  - Internal shift registers, bit counter and borrow flip-flop are cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - busy = 0, done = 0.
  - On a rising edge with start = 1: capture A, B and Bin into internal registers, set bit counter = 0, go to RUN.
  - The borrow flip-flop is loaded with Bin.
- RUN:
  - busy = 1.
  - Each edge processes bit i (= counter) using the captured LSBs a, b and borrow flip-flop br:
    - d = a ^ b ^ br
    - br_next = (~a & b) | (~(a ^ b) & br)
  - d is shifted into the result register from the MSB side. The operand registers shift right by one. The counter increments.
  - On the edge that processes bit N-1:
    - Diff <= assembled result.
    - Bout <= br_next.
    - zero <= (result == 0).
    - Go to DONE.
  - RUN lasts exactly N cycles.
- DONE:
  - busy = 0, done = 1 for exactly one cycle.
  - Next edge goes to IDLE unconditionally.
  - start is ignored in DONE.
- Latency:
  - start is accepted at edge k.
  - busy is high after edges k .. k+N-1.
  - done is high during the cycle after edge k+N.
  - The earliest next acceptance is at edge k+N+2.
- Output holding:
  - Diff, Bout and zero change only on the final RUN edge or on reset.
  - They hold through IDLE, DONE and the next RUN until that operation completes.
  - Operands may therefore change freely after acceptance.
- start during RUN or DONE: ignored; no queuing.
- Arithmetic:
  - Bout = 1 iff A < B + Bin (unsigned).
  - Diff wraps modulo 2^N (e.g. 0 - 0 - 1 = 2^N - 1).
- Reset mid-operation: the operation is aborted immediately (asynchronously) and all outputs go to reset values. No done pulse follows.
- start held high continuously: a new operation starts at each IDLE edge, i.e. one operation every N+2 cycles.

Test Plan (N = 4):
1. Basic subtraction: A=9, B=4, Bin=0, start pulsed one cycle -> busy high for 4 cycles, then done pulse; Diff=5, Bout=0, zero=0. Diff holds after done.
2. Underflow: A=3, B=5, Bin=0 -> Diff=14 (4'b1110), Bout=1. Also A=0, B=0, Bin=1 -> Diff=15, Bout=1, zero=0.
3. Zero result: A=7, B=7, Bin=0 -> Diff=0, Bout=0, zero=1. Also A=8, B=7, Bin=1 -> Diff=0, Bout=0, zero=1.
4. Ignored start and input changes:
   - Pulse start again and change A/B during RUN and during DONE -> no restart, result matches the operands captured at the first acceptance.
   - Exactly one done pulse.
   - Back-to-back operations with start held high -> done every 6 cycles.
5. Reset mid-operation: assert rst two cycles into RUN -> outputs immediately go to 0, state IDLE, no done pulse. Deassert rst, start A=12, B=5 -> Diff=7, Bout=0.
6. Exhaustive check: all 512 combinations of A, B, Bin compared against the reference model (A - B - Bin) mod 16 and the borrow rule, with latency checked to be exactly N+1 edges from acceptance to done.

Source files
------------

// File: rtl/op_resta_serial.sv
`default_nettype none
// ============================================================================
// Module   : op_resta_serial
// Purpose  : Bit-serial unsigned subtractor Diff = A - B - Bin (mod 2^N),
//            one bit per clock LSB first, with start/busy/done handshake.
// Revision : 1.0  initial release
// ============================================================================
module op_resta_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Bin,
    output logic [N-1:0] Diff,
    output logic         Bout,
    output logic         zero,
    output logic         busy,
    output logic         done
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] c_LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        r_state;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_res;
    logic [CW-1:0] r_cnt;
    logic          r_br;

    logic          w_a;
    logic          w_b;
    logic          w_d;
    logic          w_br_next;
    logic [N-1:0]  w_res_next;

    // Single full-subtractor cell operating on the current operand LSBs.
    assign w_a        = r_a[0];
    assign w_b        = r_b[0];
    assign w_d        = w_a ^ w_b ^ r_br;
    assign w_br_next  = (~w_a & w_b) | (~(w_a ^ w_b) & r_br);
    assign w_res_next = {w_d, r_res[N-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_br    <= 1'b0;
            Diff    <= '0;
            Bout    <= 1'b0;
            zero    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= A;
                        r_b     <= B;
                        r_br    <= Bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a   <= r_a >> 1;
                    r_b   <= r_b >> 1;
                    r_br  <= w_br_next;
                    r_res <= w_res_next;
                    r_cnt <= r_cnt + CW'(1);
                    // Results are published only when the last bit is formed.
                    if (r_cnt == c_LAST) begin
                        Diff    <= w_res_next;
                        Bout    <= w_br_next;
                        zero    <= (w_res_next == '0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
